dist_sched: RTL and testbench

Sequencer that owns one pass of the pairwise-distance engine. On `start` it clears the engine, streams exactly `NUM_POINTS` 3D points from an upstream source into it through a registered skid stage, then waits for the engine's `done` plus pipeline drain. It also counts emitted connections and reports `busy`/`done` to the top-level controller. It sits between the puzzle input parser and the distance calculator and gates when downstream connection consumers may treat the connection stream as complete.

---
 rtl/dist_sched.sv | 211 +++++++++++++++++++++
 tb/tb_dist_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_sched.sv
// dist_sched: runs one pass of the pairwise-distance engine: clear it, stream NUM_POINTS points
// through a 2-entry skid stage, then wait for engine done plus drain. Checks enabled by DIST_SCHED_CHECK_EN.
module dist_sched #(
    parameter int NUM_POINTS = 1000,
    parameter int DIM_W      = 17,
    parameter int EXP_CONNS  = NUM_POINTS * (NUM_POINTS - 1) / 2,
    parameter int DRAIN_CYC  = 4,
    parameter int WDOG_CYC   = 4096,
    localparam int CNT_W     = $clog2(NUM_POINTS + 1),
    localparam int CONN_W    = $clog2(EXP_CONNS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic [DIM_W-1:0]  src_locs [3],
    input  logic              src_vld,
    output logic              src_rdy,
    output logic [DIM_W-1:0]  calc_locs [3],
    output logic              calc_locs_vld,
    input  logic              calc_locs_rdy,
    output logic              calc_clr,
    input  logic              calc_conn_vld,
    input  logic              calc_done,
    output logic [CNT_W-1:0]  pts_sent,
    output logic [CONN_W-1:0] conn_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0]  NP_LAST  = CNT_W'(NUM_POINTS - 1);
    localparam logic [CNT_W-1:0]  NP_ALL   = CNT_W'(NUM_POINTS);
    localparam logic [CONN_W-1:0] CONN_MAX = '1;
    localparam int                DC_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DC_W-1:0]   DC_LAST  = DC_W'(DRAIN_CYC - 1);

    logic [2:0]        state, state_nxt;
    logic [1:0]        clr_cnt;
    logic [1:0]        sk_cnt, sk_cnt_nxt;
    logic [DIM_W-1:0]  sk_ent0 [3];
    logic [DIM_W-1:0]  sk_ent1 [3];
    logic [CNT_W-1:0]  src_cnt, src_cnt_nxt;
    logic              src_rdy_q;
    logic [CNT_W-1:0]  pts_q;
    logic [CONN_W-1:0] conn_q, conn_nxt;
    logic              drn_seen;
    logic [DC_W-1:0]   drn_cnt;
    logic              start_ok, abort_ok, push, pop, conn_inc;

    assign start_ok = start && (state == S_IDLE);
    assign abort_ok = abort && (state != S_IDLE);
    assign push     = src_vld && src_rdy_q;
    assign pop      = calc_locs_vld && calc_locs_rdy;
    assign conn_inc = calc_conn_vld && ((state == S_FEED) || (state == S_DRAIN));

`ifdef DIST_SCHED_CHECK_EN
    localparam int                WD_W   = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LIM = WD_W'(WDOG_CYC);
    localparam logic [CONN_W-1:0] EXP_C  = CONN_W'(EXP_CONNS);

    logic [WD_W-1:0] wdog_cnt;
    logic            wdog_trip;
    logic            err_q;

    assign wdog_trip = (state == S_DRAIN) && !drn_seen && !calc_done && (wdog_cnt == WD_LIM);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: if (clr_cnt == 2'd1) state_nxt = S_FEED;
            S_FEED:  if (pop && (pts_q == NP_LAST)) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (drn_seen && (drn_cnt == DC_LAST)) state_nxt = S_DONE;
`ifdef DIST_SCHED_CHECK_EN
                else if (wdog_trip) state_nxt = S_DONE;
`endif
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort_ok) state_nxt = S_IDLE;
    end

    always_comb begin
        sk_cnt_nxt = sk_cnt;
        if (start_ok || abort_ok)
            sk_cnt_nxt = 2'd0;
        else if (push && !pop)
            sk_cnt_nxt = sk_cnt + 2'd1;
        else if (pop && !push)
            sk_cnt_nxt = sk_cnt - 2'd1;
    end

    always_comb begin
        src_cnt_nxt = start_ok ? '0 : (src_cnt + CNT_W'(push));
        conn_nxt    = conn_q;
        if (start_ok)
            conn_nxt = '0;
        else if (conn_inc && (conn_q != CONN_MAX))
            conn_nxt = conn_q + 1'b1;
    end

    // control stage: sequencing, skid occupancy, counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            clr_cnt   <= 2'd0;
            sk_cnt    <= 2'd0;
            src_cnt   <= '0;
            src_rdy_q <= 1'b0;
            pts_q     <= '0;
            conn_q    <= '0;
            drn_seen  <= 1'b0;
            drn_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            sk_cnt  <= sk_cnt_nxt;
            src_cnt <= src_cnt_nxt;
            conn_q  <= conn_nxt;
            // ready looks one cycle ahead so a push next cycle always has room
            src_rdy_q <= (state_nxt == S_FEED) && (sk_cnt_nxt != 2'd2) && (src_cnt_nxt != NP_ALL);

            if (start_ok || abort_ok)
                clr_cnt <= 2'd2;
            else if (clr_cnt != 2'd0)
                clr_cnt <= clr_cnt - 2'd1;

            if (start_ok)
                pts_q <= '0;
            else if (pop)
                pts_q <= pts_q + 1'b1;

            if (state != S_DRAIN) begin
                drn_seen <= 1'b0;
                drn_cnt  <= '0;
            end else if (!drn_seen) begin
                drn_seen <= calc_done;
            end else begin
                drn_cnt <= drn_cnt + 1'b1;
            end
        end
    end

    // data stage: skid entries, entry 0 is the head presented to the engine
    always_ff @(posedge clk) begin
        case (sk_cnt)
            2'd0: begin
                if (push) sk_ent0 <= src_locs;
            end
            2'd1: begin
                if (push && pop)
                    sk_ent0 <= src_locs;
                else if (push)
                    sk_ent1 <= src_locs;
            end
            default: begin
                if (pop) begin
                    sk_ent0 <= sk_ent1;
                    if (push) sk_ent1 <= src_locs;
                end
            end
        endcase
    end

`ifdef DIST_SCHED_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != S_DRAIN)
                wdog_cnt <= '0;
            else if (!wdog_trip)
                wdog_cnt <= wdog_cnt + 1'b1;

            if (start_ok)
                err_q <= 1'b0;
            else if ((state == S_DRAIN) && (state_nxt == S_DONE) && (wdog_trip || (conn_nxt != EXP_C)))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // watchdog compiled out; WDOG_CYC stays for a uniform parameter interface
    assign err = 1'b0 & (WDOG_CYC == 0);
`endif

    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign src_rdy       = src_rdy_q;
    assign calc_locs_vld = (sk_cnt != 2'd0);
    assign calc_clr      = (clr_cnt != 2'd0);
    assign pts_sent      = pts_q;
    assign conn_cnt      = conn_q;

    always_comb begin
        for (int i = 0; i < 3; i++)
            calc_locs[i] = calc_locs_vld ? sk_ent0[i] : '0;
    end

endmodule

// File: tb/tb_dist_sched.sv
// Directed bench for dist_sched with a small engine/source model (NUM_POINTS=4, EXP_CONNS=6).
module tb_dist_sched;

    localparam int NP  = 4;
    localparam int DW  = 17;
    localparam int EXP = 6;
    localparam int CW  = $clog2(NP + 1);
    localparam int KW  = $clog2(EXP + 1);

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          busy, done, err;
    logic [DW-1:0] src_locs [3];
    logic          src_vld, src_rdy;
    logic [DW-1:0] calc_locs [3];
    logic          calc_locs_vld, calc_locs_rdy, calc_clr;
    logic          calc_conn_vld, calc_done;
    logic [CW-1:0] pts_sent;
    logic [KW-1:0] conn_cnt;

    always #5 clk = ~clk;

    dist_sched #(
        .NUM_POINTS(NP), .DIM_W(DW), .EXP_CONNS(EXP), .DRAIN_CYC(4), .WDOG_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .src_locs(src_locs), .src_vld(src_vld), .src_rdy(src_rdy),
        .calc_locs(calc_locs), .calc_locs_vld(calc_locs_vld), .calc_locs_rdy(calc_locs_rdy),
        .calc_clr(calc_clr), .calc_conn_vld(calc_conn_vld), .calc_done(calc_done),
        .pts_sent(pts_sent), .conn_cnt(conn_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [DW-1:0]   pts [8][3];
    logic [3*DW-1:0] rx_q [$];
    logic [3*DW-1:0] hs_locs, stall_locs;
    int  src_n, src_idx, rdy_mode, n_conn_cfg, eng_cnt, conn_left;
    int  cyc, n_done, stab_err, rdy_full_err, d_cyc, done_cyc, drn_cyc;
    bit  done_en, fire_src, fire_calc, prev_stall, got;

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_chk++;
        if (got_v === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got_v, exp_v);
    endtask

    // One clock: observe after the edge, advance the source/engine model, drive the next inputs.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (fire_src) src_idx++;
        if (fire_calc) begin
            rx_q.push_back(hs_locs);
            eng_cnt++;
        end
        if (prev_stall && (!calc_locs_vld || ({calc_locs[0], calc_locs[1], calc_locs[2]} != stall_locs)))
            stab_err++;
        if (done) n_done++;
        if ((src_n == NP) && (src_idx >= NP) && src_rdy) rdy_full_err++;
        if (calc_clr) begin
            eng_cnt   = 0;
            conn_left = n_conn_cfg;
        end
        calc_conn_vld = 1'b0;
        if (!calc_clr && (eng_cnt >= NP) && (conn_left > 0)) begin
            calc_conn_vld = 1'b1;
            conn_left--;
        end
        calc_done = done_en && !calc_clr && (eng_cnt >= NP) && (conn_left == 0) && !calc_conn_vld;
        if (calc_done && busy && (pts_sent == CW'(NP)) && (d_cyc < 0)) d_cyc = cyc;
        src_vld = (src_idx < src_n);
        for (int k = 0; k < 3; k++) src_locs[k] = pts[src_idx][k];
        calc_locs_rdy = (rdy_mode == 0) ? 1'b1 : cyc[0];
        fire_src   = src_vld && src_rdy;
        fire_calc  = calc_locs_vld && calc_locs_rdy;
        hs_locs    = {calc_locs[0], calc_locs[1], calc_locs[2]};
        prev_stall = calc_locs_vld && !calc_locs_rdy;
        stall_locs = hs_locs;
    endtask

    task automatic new_pass(input int n_src, input int rmode, input int nconn, input bit den);
        src_n = n_src; src_idx = 0; rdy_mode = rmode; n_conn_cfg = nconn; done_en = den;
        src_vld = 1'b0; fire_src = 1'b0;
        rx_q.delete();
        n_done = 0; rdy_full_err = 0; d_cyc = -1; done_cyc = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic check_order(input string tag, input int n);
        check({tag, "_nhs"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check({tag, "_pt"}, 64'(rx_q[i]), 64'({pts[i][0], pts[i][1], pts[i][2]}));
    endtask

    initial begin
        int busy_gap;
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 3; k++)
                pts[i][k] = DW'((i + 1) * 4099 + k * 37);
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_vld = 1'b0; calc_locs_rdy = 1'b1; calc_conn_vld = 1'b0; calc_done = 1'b0;
        for (int k = 0; k < 3; k++) src_locs[k] = '0;
        cyc = 0; stab_err = 0; eng_cnt = 0; conn_left = 0;
        fire_calc = 1'b0; prev_stall = 1'b0;
        new_pass(0, 0, 0, 1'b0);
        step();
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_src_rdy", 64'(src_rdy), 64'd0);
        check("rst_vld", 64'(calc_locs_vld), 64'd0);
        check("rst_clr", 64'(calc_clr), 64'd0);
        check("rst_pts", 64'(pts_sent), 64'd0);
        check("rst_conn", 64'(conn_cnt), 64'd0);
        check("rst_locs", 64'(calc_locs[0]), 64'd0);
        rst = 1'b0;
        step();

        // A: full-throughput pass
        new_pass(4, 0, 6, 1'b1);
        pulse_start();
        check("A_busy_t1", 64'(busy), 64'd1);
        check("A_clr_t1", 64'(calc_clr), 64'd1);
        step();
        check("A_clr_t2", 64'(calc_clr), 64'd1);
        check("A_rdy_t2", 64'(src_rdy), 64'd0);
        step();
        check("A_clr_t3", 64'(calc_clr), 64'd0);
        check("A_rdy_t3", 64'(src_rdy), 64'd1);
        busy_gap = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            if (done) begin
                got = 1'b1;
                done_cyc = cyc;
            end else if (!busy) busy_gap++;
        end
        check("A_done_seen", 64'(got), 64'd1);
        check("A_busy_gap", 64'(busy_gap), 64'd0);
        check("A_done_lat", 64'(done_cyc - d_cyc), 64'd5);
        check("A_pts", 64'(pts_sent), 64'd4);
        check("A_conn", 64'(conn_cnt), 64'd6);
        check("A_err", 64'(err), 64'd0);
        calc_conn_vld = 1'b1;
        step();
        check("A_busy_idle", 64'(busy), 64'd0);
        check("A_done_once", 64'(done), 64'd0);
        check("A_conn_done_strobe", 64'(conn_cnt), 64'd6);
        calc_conn_vld = 1'b1;
        step();
        check("A_conn_idle_strobe", 64'(conn_cnt), 64'd6);
        check("A_ndone", 64'(n_done), 64'd1);
        check_order("A", 4);

        // B: engine ready toggling, source back-to-back
        new_pass(4, 1, 6, 1'b1);
        pulse_start();
        run_to_done(80, got);
        check("B_done_seen", 64'(got), 64'd1);
        check("B_stable", 64'(stab_err), 64'd0);
        check("B_rdy_full", 64'(rdy_full_err), 64'd0);
        check("B_pts", 64'(pts_sent), 64'd4);
        check("B_conn", 64'(conn_cnt), 64'd6);
        check_order("B", 4);
        step();

        // C: abort in FEED after two points, then a clean pass
        new_pass(2, 0, 6, 1'b1);
        pulse_start();
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (pts_sent == CW'(2)) got = 1'b1;
        end
        check("C_two_sent", 64'(got), 64'd1);
        step();
        check("C_busy_pre", 64'(busy), 64'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("C_busy_a1", 64'(busy), 64'd0);
        check("C_clr_a1", 64'(calc_clr), 64'd1);
        check("C_vld_a1", 64'(calc_locs_vld), 64'd0);
        check("C_src_rdy_a1", 64'(src_rdy), 64'd0);
        step();
        check("C_clr_a2", 64'(calc_clr), 64'd1);
        step();
        check("C_clr_a3", 64'(calc_clr), 64'd0);
        check("C_no_done", 64'(n_done), 64'd0);
        check("C_pts_held", 64'(pts_sent), 64'd2);
        new_pass(4, 0, 6, 1'b1);
        pulse_start();
        check("C2_pts_clr", 64'(pts_sent), 64'd0);
        check("C2_conn_clr", 64'(conn_cnt), 64'd0);
        run_to_done(60, got);
        check("C2_done_seen", 64'(got), 64'd1);
        check("C2_pts", 64'(pts_sent), 64'd4);
        check("C2_conn", 64'(conn_cnt), 64'd6);
        step();

        // D: start while busy is ignored; start+abort together in IDLE starts a pass
        new_pass(4, 0, 6, 1'b1);
        pulse_start();
        step();
        step();
        pulse_start();
        check("D_clr_ignored", 64'(calc_clr), 64'd0);
        check("D_busy", 64'(busy), 64'd1);
        run_to_done(60, got);
        check("D_done_seen", 64'(got), 64'd1);
        check("D_pts", 64'(pts_sent), 64'd4);
        step();
        check("D_ndone", 64'(n_done), 64'd1);
        new_pass(4, 0, 6, 1'b1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("D2_busy", 64'(busy), 64'd1);
        check("D2_clr", 64'(calc_clr), 64'd1);
        run_to_done(60, got);
        check("D2_done_seen", 64'(got), 64'd1);
        check("D2_conn", 64'(conn_cnt), 64'd6);
        step();

`ifdef DIST_SCHED_CHECK_EN
        // E: watchdog with calc_done held low, then a short connection count
        new_pass(4, 0, 6, 1'b0);
        pulse_start();
        drn_cyc = -1;
        for (int i = 0; i < 30 && drn_cyc < 0; i++) begin
            step();
            if (busy && (pts_sent == CW'(NP))) drn_cyc = cyc;
        end
        run_to_done(40, got);
        check("E_wdog_done", 64'(got), 64'd1);
        check("E_wdog_lat", 64'(done_cyc - drn_cyc), 64'd17);
        check("E_wdog_err", 64'(err), 64'd1);
        step();
        new_pass(4, 0, 5, 1'b1);
        pulse_start();
        check("E_err_clr", 64'(err), 64'd0);
        run_to_done(60, got);
        check("E_cnt_done", 64'(got), 64'd1);
        check("E_cnt_err", 64'(err), 64'd1);
        step();
`else
        // E: without checks DRAIN waits for calc_done indefinitely
        new_pass(4, 0, 6, 1'b0);
        pulse_start();
        for (int i = 0; i < 60; i++) step();
        check("E_no_done", 64'(n_done), 64'd0);
        check("E_still_busy", 64'(busy), 64'd1);
        check("E_err_tied", 64'(err), 64'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("E_abort_idle", 64'(busy), 64'd0);
        step();
`endif

        check("stable_all", 64'(stab_err), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
